// File: rtl/pe_func_unit_flow_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_func_unit_flow_control_seq
// Purpose  : Instruction-level sequencer for one PE functional unit. Accepts
//            one instruction at a time, enables its load interfaces, waits
//            until every enabled load reports unblocked, times the execute
//            latency, runs the optional store interface and finally pulses
//            o_instr_done to clear the done state of every interface unit.
// Ports    :
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous reset, active-high
//   i_instr_vld         in   decoder offers an instruction
//   o_instr_rdy         out  sequencer accepts (handshake = vld & rdy)
//   i_instr_ld_en       in   [N_LD]  load interfaces used by the instruction
//   i_instr_st_en       in   instruction writes through the store interface
//   i_instr_lat         in   [LAT_W] execute latency in cycles (0 allowed)
//   o_ld_ifc_en         out  [N_LD]  enable to each load flow-control unit
//   i_ld_ifc_unblocked  in   [N_LD]  unblocked status from each load unit
//   o_st_ifc_en         out  enable to the store flow-control unit
//   i_st_ifc_unblocked  in   unblocked status from the store unit
//   o_instr_done        out  one-cycle completion broadcast
//   o_exec_start        out  one-cycle pulse: operands complete, FU starts
//   o_busy              out  state is not IDLE
//   o_instr_cnt         out  [CNT_W] completed instructions, wraps
// Revision : 1.0 - initial release
// ============================================================================
module pe_func_unit_flow_control_seq #(
  parameter int unsigned N_LD  = 2,
  parameter int unsigned LAT_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_instr_vld,
  output logic             o_instr_rdy,
  input  logic [N_LD-1:0]  i_instr_ld_en,
  input  logic             i_instr_st_en,
  input  logic [LAT_W-1:0] i_instr_lat,
  output logic [N_LD-1:0]  o_ld_ifc_en,
  input  logic [N_LD-1:0]  i_ld_ifc_unblocked,
  output logic             o_st_ifc_en,
  input  logic             i_st_ifc_unblocked,
  output logic             o_instr_done,
  output logic             o_exec_start,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  localparam logic [LAT_W-1:0] c_lat_zero = '0;
  localparam logic [LAT_W-1:0] c_lat_one  = LAT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [N_LD-1:0]  r_ld_msk;
  logic             r_st_f;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  logic w_hs;
  logic w_ld_ok;
  logic w_lat_zero;
  logic w_exec_last;

  // Loads outside the latched mask count as satisfied, so an empty mask
  // lets LOAD finish in its first cycle.
  assign w_ld_ok     = &(i_ld_ifc_unblocked | ~r_ld_msk);
  assign w_lat_zero  = (r_lat == c_lat_zero);
  assign w_exec_last = (r_cnt == c_lat_one);
  assign w_hs        = i_instr_vld & o_instr_rdy;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_instr_vld) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_ld_ok) begin
          if (!w_lat_zero) begin
            w_state_nxt = S_EXEC;
          end else if (r_st_f) begin
            w_state_nxt = S_STORE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_EXEC: begin
        if (w_exec_last) begin
          w_state_nxt = r_st_f ? S_STORE : S_IDLE;
        end
      end
      S_STORE: begin
        if (i_st_ifc_unblocked) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: purely state plus the current unblocked inputs, so the
  // completion pulse coincides with the final store unblock.
  // --------------------------------------------------------------------------
  always_comb begin
    o_instr_rdy  = 1'b0;
    o_busy       = 1'b1;
    o_ld_ifc_en  = '0;
    o_st_ifc_en  = 1'b0;
    o_exec_start = 1'b0;
    o_instr_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_instr_rdy = 1'b1;
        o_busy      = 1'b0;
      end
      S_LOAD: begin
        o_ld_ifc_en  = r_ld_msk;
        o_exec_start = w_ld_ok;
        o_instr_done = w_ld_ok & w_lat_zero & ~r_st_f;
      end
      S_EXEC: begin
        o_instr_done = w_exec_last & ~r_st_f;
      end
      S_STORE: begin
        o_st_ifc_en  = 1'b1;
        o_instr_done = i_st_ifc_unblocked;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction fields: captured only on the handshake, so decoder activity
  // while busy cannot disturb the running instruction.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_msk <= '0;
      r_st_f   <= 1'b0;
      r_lat    <= '0;
    end else if (w_hs) begin
      r_ld_msk <= i_instr_ld_en;
      r_st_f   <= i_instr_st_en;
      r_lat    <= i_instr_lat;
    end
  end

  // --------------------------------------------------------------------------
  // Execute latency counter: loaded as LOAD hands over to EXEC, so EXEC
  // spans exactly r_lat cycles and ends in the cycle the count reads 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_LOAD) && w_ld_ok) begin
      r_cnt <= r_lat;
    end else if (r_state == S_EXEC) begin
      r_cnt <= r_cnt - c_lat_one;
    end
  end

  // --------------------------------------------------------------------------
  // Completed-instruction counter, free-running modulo 2^CNT_W.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_cnt <= '0;
    end else if (o_instr_done) begin
      r_instr_cnt <= r_instr_cnt + c_cnt_one;
    end
  end

  assign o_instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pe_func_unit_flow_control_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_func_unit_flow_control_seq
// Purpose  : Self-checking bench for pe_func_unit_flow_control_seq. Each
//            instruction's expected timeline is derived from its phase
//            lengths (load wait, latency, store wait); a second instance with
//            a 4-bit counter exercises counter wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_func_unit_flow_control_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [1:0]  ld_en = '0;
  logic        st_en = 1'b0;
  logic [3:0]  lat = '0;
  logic [1:0]  ld_unb = '0;
  logic        st_unb = 1'b0;

  logic        rdy, st_ifc_en, done, es, busy;
  logic [1:0]  ld_ifc_en;
  logic [15:0] icnt;

  logic        w_vld = 1'b0;
  logic        w_rdy, w_st_ifc_en, w_done, w_es, w_busy;
  logic [1:0]  w_ld_ifc_en;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned exp_cnt = 0;
  bit hold_vld = 1'b0;

  always #5 clk = ~clk;

  pe_func_unit_flow_control_seq #(.N_LD(2), .LAT_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_instr_vld(vld), .o_instr_rdy(rdy),
    .i_instr_ld_en(ld_en), .i_instr_st_en(st_en), .i_instr_lat(lat),
    .o_ld_ifc_en(ld_ifc_en), .i_ld_ifc_unblocked(ld_unb),
    .o_st_ifc_en(st_ifc_en), .i_st_ifc_unblocked(st_unb),
    .o_instr_done(done), .o_exec_start(es), .o_busy(busy),
    .o_instr_cnt(icnt)
  );

  pe_func_unit_flow_control_seq #(.N_LD(2), .LAT_W(4), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst),
    .i_instr_vld(w_vld), .o_instr_rdy(w_rdy),
    .i_instr_ld_en(2'b00), .i_instr_st_en(1'b0), .i_instr_lat(4'd0),
    .o_ld_ifc_en(w_ld_ifc_en), .i_ld_ifc_unblocked(2'b11),
    .o_st_ifc_en(w_st_ifc_en), .i_st_ifc_unblocked(1'b1),
    .o_instr_done(w_done), .o_exec_start(w_es), .o_busy(w_busy),
    .o_instr_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string ph, input logic e_rdy, input logic e_busy,
                          input logic [1:0] e_lden, input logic e_sten,
                          input logic e_es, input logic e_done);
    chk({ph, "_rdy"},   32'(rdy),       32'(e_rdy));
    chk({ph, "_busy"},  32'(busy),      32'(e_busy));
    chk({ph, "_lden"},  32'(ld_ifc_en), 32'(e_lden));
    chk({ph, "_sten"},  32'(st_ifc_en), 32'(e_sten));
    chk({ph, "_es"},    32'(es),        32'(e_es));
    chk({ph, "_done"},  32'(done),      32'(e_done));
    chk({ph, "_cnt"},   32'(icnt),      32'(exp_cnt[15:0]));
  endtask

  // Scramble every input the busy sequencer is supposed to ignore.
  task automatic scramble_busy();
    vld   = hold_vld ? 1'b1 : 1'($urandom);
    ld_en = 2'($urandom);
    st_en = 1'($urandom);
    lat   = 4'($urandom);
  endtask

  task automatic idle_cycle();
    vld    = 1'b0;
    ld_en  = 2'($urandom);
    ld_unb = 2'($urandom);
    st_unb = 1'($urandom);
    @(negedge clk);
    chk_outs("idle", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  // One instruction: phase lengths follow directly from the instruction
  // rules -- LOAD lasts 1 + load-stall cycles (1 for an empty mask), EXEC
  // lasts lat cycles, STORE lasts 1 + store-stall cycles when enabled.
  task automatic run_instr(input logic [1:0] m, input logic s, input logic [3:0] l,
                           input int ld_stall, input int st_stall);
    int n_ld;
    int n_st;
    logic [1:0] hb;
    logic e_done;
    n_ld = (m == 2'b00) ? 1 : ld_stall + 1;
    n_st = s ? st_stall + 1 : 0;
    hb   = m[1] ? 2'b10 : 2'b01;

    vld = 1'b1; ld_en = m; st_en = s; lat = l;
    ld_unb = 2'($urandom); st_unb = 1'($urandom);
    @(negedge clk);
    chk_outs("hs", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < n_ld; i++) begin
      scramble_busy();
      st_unb = 1'($urandom);
      if (i == n_ld - 1) ld_unb = m | 2'($urandom);
      else               ld_unb = 2'($urandom) & ~hb;
      e_done = (i == n_ld - 1) && (l == 4'd0) && !s;
      @(negedge clk);
      chk_outs("load", 1'b0, 1'b1, m, 1'b0, (i == n_ld - 1), e_done);
      @(posedge clk); #1;
      if (e_done) exp_cnt++;
    end

    for (int i = 0; i < int'(l); i++) begin
      scramble_busy();
      ld_unb = 2'($urandom); st_unb = 1'($urandom);
      e_done = (i == int'(l) - 1) && !s;
      @(negedge clk);
      chk_outs("exec", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, e_done);
      @(posedge clk); #1;
      if (e_done) exp_cnt++;
    end

    for (int i = 0; i < n_st; i++) begin
      scramble_busy();
      ld_unb = 2'($urandom);
      st_unb = (i == n_st - 1);
      e_done = (i == n_st - 1);
      @(negedge clk);
      chk_outs("store", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, e_done);
      @(posedge clk); #1;
      if (e_done) exp_cnt++;
    end
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outs("rst", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- reset abandons an instruction in STORE -------------
    vld = 1'b1; ld_en = 2'b00; st_en = 1'b1; lat = 4'd0; ld_unb = 2'b00; st_unb = 1'b0;
    @(posedge clk); #1;                       // LOAD
    vld = 1'b0;
    @(posedge clk); #1;                       // STORE, store blocked
    @(negedge clk);
    chk_outs("pre_rst_store", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_outs("async_rst", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_outs("held_rst", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycle();
    chk("cnt_after_rst", 32'(icnt), 32'd0);

    // ---------------- loads stalled, both unblock together ----------------
    run_instr(2'b11, 1'b1, 4'd3, 4, 0);
    idle_cycle();

    // ---------------- back-to-back minimal instructions -------------------
    hold_vld = 1'b1;
    repeat (5) run_instr(2'b00, 1'b0, 4'd0, 0, 0);
    hold_vld = 1'b0;

    // ---------------- store stalled for 5 cycles --------------------------
    run_instr(2'b10, 1'b1, 4'd1, 0, 5);

    // ---------------- randomized instructions -----------------------------
    for (int k = 0; k < 40; k++) begin
      run_instr(2'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    // ---------------- counter wrap on the 4-bit instance ------------------
    // With vld held high and an empty minimal instruction, the sequencer
    // alternates handshake / completion, so cycle c completes when c is odd.
    @(posedge clk); #1;
    w_vld = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("wrap_done", 32'(w_done), 32'(c % 2));
      chk("wrap_rdy",  32'(w_rdy),  32'(1 - (c % 2)));
      @(posedge clk); #1;
      chk("wrap_cnt",  32'(w_cnt),  32'(((c + 1) / 2) % 16));
    end
    w_vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_func_unit_flow_control_seq.md
# pe_func_unit_flow_control_seq

Instruction-level sequencer for one PE functional unit. It accepts one instruction at a time and enables that instruction's load interfaces. It waits until every enabled load interface reports unblocked, then times the functional-unit latency and runs the optional store interface. Its final action is a single-cycle `instr_done` broadcast, which clears the done state held inside every per-interface flow-control unit. It sits between the PE instruction decoder and the per-interface flow-control units (one per load port, one for the store port).

## Interface
- `N_LD`, 2: number of load interfaces.
- `LAT_W`, 4: width of the execute-latency field.
- `CNT_W`, 16: width of the completed-instruction counter.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `instr_vld`  in  1  decoder offers an instruction.
- `instr_rdy`  out  1  sequencer accepts the instruction (handshake fires on `instr_vld & instr_rdy`).
- `instr_ld_en`  in  N_LD  mask of load interfaces used by the instruction.
- `instr_st_en`  in  1  instruction writes a result through the store interface.
- `instr_lat`  in  LAT_W  execute latency in cycles (0 allowed).
- `ld_ifc_en`  out  N_LD  enable to each load flow-control unit.
- `ld_ifc_unblocked`  in  N_LD  unblocked status from each load flow-control unit.
- `st_ifc_en`  out  1  enable to the store flow-control unit.
- `st_ifc_unblocked`  in  1  unblocked status from the store flow-control unit.
- `instr_done`  out  1  one-cycle completion pulse, broadcast to all interface units.
- `exec_start`  out  1  one-cycle pulse: operands are complete and the functional unit starts.
- `busy`  out  1  state is not IDLE.
- `instr_cnt`  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W.

## Operation
- The state machine has four states: IDLE, LOAD, EXEC, STORE.
- IDLE
  - `instr_rdy`=1.
  - On handshake: latch `instr_ld_en`, `instr_st_en` and `instr_lat` into `ld_msk`, `st_f` and `lat`; go to LOAD.
- LOAD
  - `ld_ifc_en` = `ld_msk`.
  - Condition `ld_ok` = &(`ld_ifc_unblocked` | ~`ld_msk`).
  - If `ld_ok`: pulse `exec_start`, then choose the next state:
    - `lat`≠0 → EXEC, with counter loaded with `lat`;
    - `lat`=0 and `st_f`=1 → STORE;
    - `lat`=0 and `st_f`=0 → complete.
  - An all-zero mask satisfies `ld_ok` immediately: LOAD lasts exactly one cycle.
- EXEC
  - Counter decrements by 1 per cycle.
  - In the cycle the counter equals 1, go to STORE if `st_f`=1, otherwise complete.
  - EXEC therefore lasts exactly `lat` cycles.
- STORE
  - `st_ifc_en`=1.
  - Complete in any cycle where `st_ifc_unblocked`=1; otherwise hold.
- Complete
  - `instr_done`=1 combinationally in the completion cycle.
  - `instr_cnt` increments; next state is IDLE.
- `ld_ifc_en`=0 outside LOAD; `st_ifc_en`=0 outside STORE.
  - The interface units keep their done state until `instr_done` clears it.
- `instr_done` is asserted in the same cycle as the final store unblock. The store interface must not latch a new done bit in that cycle.
- Latched fields are ignored until the next handshake. Input changes during a busy instruction have no effect.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, counter=0, `ld_msk`=0, `st_f`=0, `lat`=0, `instr_cnt`=0.
  - Outputs: `instr_rdy`=1; `busy`, `instr_done`, `exec_start`, `ld_ifc_en`, `st_ifc_en` all 0.
- Reset mid-instruction abandons the instruction without an `instr_done` pulse.
- `instr_rdy`, `ld_ifc_en`, `st_ifc_en`, `exec_start`, `instr_done` and `busy` are decoded from state plus the current `*_unblocked` inputs. There are no registered outputs apart from `instr_cnt`.
- Handshake at cycle T gives LOAD at T+1. If loads are already unblocked:
  - `exec_start` at T+1;
  - EXEC spans T+2..T+1+`lat`;
  - STORE starts at T+2+`lat`;
  - `instr_done` at T+2+`lat` if the store is unblocked.
- Minimum instruction (`lat`=0, no store): handshake at T, `instr_done` at T+1, next handshake possible at T+2.
- There is one IDLE bubble between instructions. The sequencer never overlaps two instructions.
- `instr_cnt` updates on the clock edge that ends the completion cycle. It wraps from 2^CNT_W−1 to 0.

## Test plan
- Reset asserted in STORE with `st_ifc_unblocked`=0:
  - expect every output at its reset value immediately;
  - expect no `instr_done`;
  - expect `instr_cnt` unchanged at 0 after reset is released.
- `ld_en`=2'b11, `lat`=3, `st_en`=1; `ld_ifc_unblocked`=2'b01 for 4 cycles, then 2'b11; store unblocked at once:
  - expect `exec_start` exactly once, in the cycle both loads are unblocked;
  - expect 3 EXEC cycles;
  - expect `instr_done` at the 4th cycle after `exec_start`.
- `ld_en`=0, `lat`=0, `st_en`=0, with `instr_vld` held high:
  - expect `instr_done` every 2 cycles;
  - expect `instr_rdy` toggling 1/0;
  - expect `instr_cnt` incrementing by 1 per instruction.
- `ld_en`=2'b10, `lat`=1, `st_en`=1, with `st_ifc_unblocked` low for 5 cycles:
  - expect `st_ifc_en` held high for 6 cycles;
  - expect `instr_done` only in the 6th;
  - expect `ld_ifc_en`=0 throughout STORE.
- Change `instr_ld_en` and `instr_lat` while busy: expect the latched values to be used unaltered.
- Preload `instr_cnt`=0xFFFF, then complete one instruction: expect `instr_cnt`=0x0000.
